// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences one load/store from the pipeline onto a req/ack data-memory port.
// Optional build macro MISALIGN_TRAP_EN: fault misaligned half/word accesses instead of issuing them.
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_size,
  input  logic              mem_sign,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              done,
  output logic              misalign,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_be,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata,
  input  logic              dm_ack
);

  // state | meaning
  // IDLE  | waiting for a load/store request
  // REQ   | dm_req held with stable dm_* until dm_ack
  // DONE  | single-cycle completion, done pulse
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        size_q;
  logic              sign_q;
  logic              we_q;
  logic              req_present;
  logic              mis_now;
  logic [3:0]        be_c;
  logic [31:0]       wdata_c;
  logic [7:0]        byte_l;
  logic [15:0]       half_l;
  logic [31:0]       load_ext;

  assign req_present = (mem_read | mem_write) & (mem_size != 2'b00);

`ifdef MISALIGN_TRAP_EN
  logic mis_q;
  assign mis_now = ((mem_size == 2'b10) & addr[0]) |
                   ((mem_size == 2'b11) & (addr[1:0] != 2'b00));

  always_ff @(posedge clk) begin
    if (reset)
      mis_q <= 1'b0;
    else if (state == IDLE)
      mis_q <= req_present & mis_now;
  end

  assign misalign = ~reset & (state == DONE) & mis_q;
`else
  assign mis_now  = 1'b0;
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      we_q    <= 1'b0;
      rdata   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_present) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        size_q  <= mem_size;
        sign_q  <= mem_sign;
        we_q    <= mem_write;  // read+write together resolves to a store
      end
      if (state == REQ && dm_ack && !we_q)
        rdata <= load_ext;
    end
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    done      = 1'b0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    case (state)
      IDLE: begin
        stall = req_present & ~reset;
        if (req_present)
          state_nxt = mis_now ? DONE : REQ;
      end
      REQ: begin
        stall  = ~reset;
        dm_req = 1'b1;
        dm_we  = we_q;
        if (dm_ack)
          state_nxt = DONE;
      end
      DONE: begin
        done      = ~reset;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    be_c    = 4'b0000;
    wdata_c = wdata_q;
    case (size_q)
      2'b01: begin
        be_c    = 4'b0001 << addr_q[1:0];
        wdata_c = {4{wdata_q[7:0]}};
      end
      2'b10: begin
        be_c    = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{wdata_q[15:0]}};
      end
      2'b11:   be_c = 4'b1111;
      default: be_c = 4'b0000;
    endcase
  end

  always_comb begin
    byte_l = dm_rdata[7:0];
    case (addr_q[1:0])
      2'b00:   byte_l = dm_rdata[7:0];
      2'b01:   byte_l = dm_rdata[15:8];
      2'b10:   byte_l = dm_rdata[23:16];
      default: byte_l = dm_rdata[31:24];
    endcase
    half_l = addr_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (size_q)
      2'b01:   load_ext = {{24{sign_q & byte_l[7]}}, byte_l};
      2'b10:   load_ext = {{16{sign_q & half_l[15]}}, half_l};
      default: load_ext = dm_rdata;
    endcase
  end

  assign dm_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign dm_be    = be_c;
  assign dm_wdata = wdata_c;

endmodule
